// File: rtl/core_mem_responder.sv
// Dual-read-port word RAM for a simple core: instruction fetch and data
// load/store share one array. A memory-mapped cycle counter and a sticky
// out-of-range flag are included.
module core_mem_responder #(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                LOAD_LATENCY   = 1,
   parameter int                MEM_DEPTH_LOG2 = 12,
   parameter logic [ADDR_W-1:0] CYCLE_ADDR     = '1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [ADDR_W-1:0]   pc_to_mem,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   st_data,
   input  logic [DATA_W/8-1:0] we,
   output logic [DATA_W-1:0]   ld_data_for_inst,
   output logic [DATA_W-1:0]   ld_data,
   output logic                err
);

   localparam int NBYTES = DATA_W / 8;
   localparam int OFF_W  = $clog2(NBYTES);
   localparam int DEPTH  = 2 ** MEM_DEPTH_LOG2;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] cycle_cnt;
   logic [DATA_W-1:0] inst_pipe [LOAD_LATENCY];
   logic [DATA_W-1:0] data_pipe [LOAD_LATENCY];

   logic [MEM_DEPTH_LOG2-1:0] inst_idx;
   logic [MEM_DEPTH_LOG2-1:0] data_idx;
   logic                      inst_ok;
   logic                      data_cyc;
   logic                      data_ok;
   logic                      oor_seen;
   logic                      store;
   logic [DATA_W-1:0]         inst_word;
   logic [DATA_W-1:0]         data_word;

   // Word index must fit in the array; byte-offset bits never matter.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a >> (OFF_W + MEM_DEPTH_LOG2)) == '0;
   endfunction

   assign inst_idx = pc_to_mem[OFF_W +: MEM_DEPTH_LOG2];
   assign data_idx = mem_addr[OFF_W +: MEM_DEPTH_LOG2];

   // Address decode and read mux. The counter address is decoded first so it
   // never counts as out of range on the data port; on the fetch port it does.
   always_comb begin
      // NOTE: every output of this block gets a value on every path, so no latch is inferred.
      inst_ok   = in_range(pc_to_mem) && (pc_to_mem != CYCLE_ADDR);
      data_cyc  = (mem_addr == CYCLE_ADDR);
      data_ok   = !data_cyc && in_range(mem_addr);
      oor_seen  = !inst_ok || (!data_cyc && !data_ok);
      store     = data_ok && (we != '0);
      inst_word = '0;
      data_word = '0;
      if (inst_ok) begin
         inst_word = mem[inst_idx];
      end
      if (data_cyc) begin
         data_word = cycle_cnt;
      end else if (data_ok) begin
         data_word = mem[data_idx];
      end
   end

   // NOTE: the RAM array has no reset; contents survive rstn and only writes are gated by it.
   always_ff @(posedge clk) begin
      if (rstn && store) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (we[b]) begin
               mem[data_idx][b*8 +: 8] <= st_data[b*8 +: 8];
            end
         end
      end
   end

   // Read pipelines, counter and sticky error. Reads see pre-write contents
   // because the array update and the capture happen at the same edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < LOAD_LATENCY; s++) begin
            inst_pipe[s] <= '0;
            data_pipe[s] <= '0;
         end
         cycle_cnt <= '0;
         err       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every stage shift on the same edge without ordering hazards.
         inst_pipe[0] <= inst_word;
         data_pipe[0] <= data_word;
         for (int s = 1; s < LOAD_LATENCY; s++) begin
            inst_pipe[s] <= inst_pipe[s-1];
            data_pipe[s] <= data_pipe[s-1];
         end
         cycle_cnt <= cycle_cnt + 1'b1;
         if (oor_seen) begin
            err <= 1'b1;
         end
      end
   end

   assign ld_data_for_inst = inst_pipe[LOAD_LATENCY-1];
   assign ld_data          = data_pipe[LOAD_LATENCY-1];

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: directed vector table, hand-written reset and
// counter sequences, then random traffic against a word-array reference model.
module tb_core_mem_responder;

   localparam int          L    = 2;
   localparam int          DL   = 6;
   localparam int          NW   = 1 << DL;
   localparam logic [31:0] CYC  = 32'hFFFF_FFFF;
   localparam logic [31:0] OOR  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [31:0] pc_to_mem = '0;
   logic [31:0] mem_addr = '0;
   logic [31:0] st_data = '0;
   logic [3:0]  we = '0;
   logic [31:0] ld_data_for_inst;
   logic [31:0] ld_data;
   logic        err;

   core_mem_responder #(
      .ADDR_W(32), .DATA_W(32), .LOAD_LATENCY(L), .MEM_DEPTH_LOG2(DL)
   ) dut (
      .clk(clk), .rstn(rstn), .pc_to_mem(pc_to_mem), .mem_addr(mem_addr),
      .st_data(st_data), .we(we), .ld_data_for_inst(ld_data_for_inst),
      .ld_data(ld_data), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain word array, edge count since reset, sticky flag.
   logic [31:0] mmem [NW];
   int unsigned cyc;
   bit          model_err;

   typedef struct { logic [31:0] i; logic [31:0] d; } exp_t;
   exp_t q[$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] st;
      logic [3:0]  we;
      logic [31:0] exp_i;
      logic [31:0] exp_d;
   } vec_t;
   vec_t tbl [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_ram(input logic [31:0] a);
      return (a / 4) < NW;
   endfunction

   function automatic logic [31:0] m_inst(input logic [31:0] a);
      if (a == CYC || !in_ram(a)) return '0;
      return mmem[a / 4];
   endfunction

   function automatic logic [31:0] m_data(input logic [31:0] a);
      if (a == CYC) return cyc;
      if (!in_ram(a)) return '0;
      return mmem[a / 4];
   endfunction

   function automatic bit m_oor(input logic [31:0] p, input logic [31:0] a);
      return (p == CYC) || !in_ram(p) || ((a != CYC) && !in_ram(a));
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] s, input logic [3:0] w);
      if (a != CYC && in_ram(a)) begin
         for (int b = 0; b < 4; b++) begin
            if (w[b]) mmem[a / 4][b*8 +: 8] = s[b*8 +: 8];
         end
      end
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge.
   task automatic step(input logic [31:0] p, input logic [31:0] a, input logic [31:0] s,
                       input logic [3:0] w, input bit chk, input bit use_exp,
                       input logic [31:0] ei, input logic [31:0] ed);
      exp_t e;
      pc_to_mem = p;
      mem_addr  = a;
      st_data   = s;
      we        = w;
      @(posedge clk);
      e.i = use_exp ? ei : m_inst(p);
      e.d = use_exp ? ed : m_data(a);
      if (m_oor(p, a)) model_err = 1'b1;
      m_write(a, s, w);
      cyc++;
      q.push_back(e);
      @(negedge clk);
      if (q.size() == L) begin
         e = q.pop_front();
         if (chk) begin
            check("ld_data_for_inst", ld_data_for_inst, e.i);
            check("ld_data", ld_data, e.d);
         end
      end else begin
         check("inst_after_reset", ld_data_for_inst, 32'h0);
         check("data_after_reset", ld_data, 32'h0);
      end
      check("err", {31'b0, err}, {31'b0, model_err});
   endtask

   task automatic rd(input logic [31:0] p, input logic [31:0] a,
                     input logic [31:0] ei, input logic [31:0] ed);
      step(p, a, 32'h0, 4'h0, 1'b1, 1'b1, ei, ed);
   endtask

   // Asserts rstn mid low-phase, checks the asynchronous clear, optionally
   // attempts a store while held in reset, releases on a falling edge.
   task automatic apply_reset(input bit wr_during);
      #2 rstn = 1'b0;
      #1;
      check("rst_ld_data", ld_data, 32'h0);
      check("rst_ld_data_for_inst", ld_data_for_inst, 32'h0);
      check("rst_err", {31'b0, err}, 32'h0);
      pc_to_mem = '0;
      mem_addr  = 32'h10;
      st_data   = 32'h0BAD_0BAD;
      we        = wr_during ? 4'hF : 4'h0;
      repeat (3) @(negedge clk);
      we        = '0;
      rstn      = 1'b1;
      q.delete();
      model_err = 1'b0;
      cyc       = 0;
   endtask

   initial begin
      logic [31:0] rp, ra, rs;
      logic [3:0]  rw;
      int unsigned r;

      tbl[0]  = '{32'h00, 32'h10, 32'hA5A5_5A5A, 4'hF, 32'h0,         32'h0};
      tbl[1]  = '{32'h10, 32'h10, 32'h0,         4'h0, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
      tbl[2]  = '{32'h14, 32'h14, 32'h1122_3344, 4'hF, 32'h0,         32'h0};
      tbl[3]  = '{32'h10, 32'h14, 32'hFFFF_FFFF, 4'h5, 32'hA5A5_5A5A, 32'h1122_3344};
      tbl[4]  = '{32'h14, 32'h14, 32'h0,         4'h0, 32'h11FF_33FF, 32'h11FF_33FF};
      tbl[5]  = '{32'h20, 32'h20, 32'hDEAD_BEEF, 4'hF, 32'h0,         32'h0};
      tbl[6]  = '{32'h00, 32'h20, 32'h0,         4'h0, 32'h0,         32'hDEAD_BEEF};
      tbl[7]  = '{32'h20, 32'h04, 32'hCAFE_0004, 4'hF, 32'hDEAD_BEEF, 32'h0};
      tbl[8]  = '{32'h04, 32'h08, 32'h0000_0008, 4'hF, 32'hCAFE_0004, 32'h0};
      tbl[9]  = '{32'h08, 32'h00, 32'h0,         4'h0, 32'h0000_0008, 32'h0};
      tbl[10] = '{32'h03, 32'h04, 32'h0,         4'h0, 32'h0,         32'hCAFE_0004};
      tbl[11] = '{32'h07, 32'h08, 32'h0,         4'h0, 32'hCAFE_0004, 32'h0000_0008};
      tbl[12] = '{32'h16, 32'h13, 32'h0,         4'h0, 32'h11FF_33FF, 32'hA5A5_5A5A};
      tbl[13] = '{32'h20, 32'h22, 32'h7700_0000, 4'h8, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[14] = '{32'h21, 32'h20, 32'h0,         4'h0, 32'h77AD_BEEF, 32'h77AD_BEEF};
      tbl[15] = '{32'hFC, 32'hFC, 32'h1234_5678, 4'hF, 32'h0,         32'h0};
      tbl[16] = '{32'hFF, 32'hFC, 32'h0,         4'h0, 32'h1234_5678, 32'h1234_5678};

      apply_reset(1'b0);

      // Fill RAM with zeros; reads during the fill see uninitialised words.
      for (int w = 0; w < NW; w++) begin
         step(32'h0, w * 4, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0);
      end

      foreach (tbl[k]) begin
         step(tbl[k].pc, tbl[k].addr, tbl[k].st, tbl[k].we, 1'b1, 1'b1,
              tbl[k].exp_i, tbl[k].exp_d);
      end

      // Counter: first post-reset sample reads 0, edges 5 and 9 read 4 and 8,
      // a store to the counter is ignored; RAM survives reset and a store
      // attempted while in reset.
      apply_reset(1'b1);
      rd(32'h0, CYC, 32'h0, 32'h0);
      repeat (3) rd(32'h0, 32'h10, 32'h0, 32'hA5A5_5A5A);
      rd(32'h0, CYC, 32'h0, 32'd4);
      repeat (3) rd(32'h0, 32'h20, 32'h0, 32'h77AD_BEEF);
      step(32'h0, CYC, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0, 32'd8);
      repeat (2) rd(32'h10, 32'h10, 32'hA5A5_5A5A, 32'hA5A5_5A5A);
      check("err_after_cycle_write", {31'b0, err}, 32'h0);

      // Out-of-range data read, then reset while results are in flight.
      rd(32'h0, 32'h10, 32'h0, 32'hA5A5_5A5A);
      rd(32'h0, OOR, 32'h0, 32'h0);
      check("err_set_oor_data", {31'b0, err}, 32'h1);
      apply_reset(1'b0);

      // Fetch-port access to the counter and beyond the array.
      rd(CYC, 32'h10, 32'h0, 32'hA5A5_5A5A);
      rd(OOR + 32'h4, 32'h10, 32'h0, 32'hA5A5_5A5A);
      rd(32'h10, 32'h10, 32'hA5A5_5A5A, 32'hA5A5_5A5A);
      rd(32'h10, 32'h10, 32'hA5A5_5A5A, 32'hA5A5_5A5A);
      check("err_set_oor_inst", {31'b0, err}, 32'h1);
      apply_reset(1'b0);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         r  = $urandom_range(99);
         if (r < 8)       ra = CYC;
         else if (r < 10) ra = OOR + $urandom_range(255);
         else             ra = $urandom_range(4 * NW - 1);
         r  = $urandom_range(99);
         if (r < 2)       rp = OOR + $urandom_range(255);
         else             rp = $urandom_range(4 * NW - 1);
         rs = $urandom;
         rw = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0;
         step(rp, ra, rs, rw, 1'b1, 1'b0, 32'h0, 32'h0);
      end
      repeat (L) step(32'h0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
